inst_prefetch_q: RTL and testbench

Instruction prefetch queue between the instruction ROM and the decode stage. It generates sequential fetch addresses and ROM chip-enable, and captures ROM read data one cycle after each issue. It buffers {pc, inst} pairs in a small FIFO and presents them to decode with a valid/ready handshake. A flush/redirect empties the queue, drops the in-flight fetch and restarts fetching at a new PC.

---
 rtl/inst_prefetch_q.sv | 126 ++++++++++++
 tb/tb_inst_prefetch_q.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_q.sv
// inst_prefetch_q
//   Instruction prefetch queue sitting between the instruction ROM and decode.
//   It issues sequential word-aligned fetches, captures ROM data one cycle after
//   each issue, and buffers {pc, inst} pairs in a DEPTH-entry FIFO. The FIFO is
//   presented to decode with a valid/ready handshake. A flush empties the queue,
//   drops any in-flight fetch and restarts fetching at the redirect target.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   rom_ce_o      one-cycle fetch strobe to the ROM
//   rom_addr_o    word-aligned fetch address (always the next PC to fetch)
//   rom_data_i    ROM data, valid the cycle after rom_ce_o
//   id_valid_o    head entry valid to decode
//   id_ready_i    decode accepts the head entry
//   id_pc_o       PC of the head entry (0 when empty)
//   id_inst_o     instruction of the head entry (0 when empty)
//   flush_i       redirect request
//   flush_pc_i    redirect target (low two bits ignored)
//   count_o       queue occupancy
module inst_prefetch_q #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [31:0]                rom_addr_o,
  input  logic [31:0]                rom_data_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [31:0]                id_pc_o,
  output logic [31:0]                id_inst_o,
  input  logic                       flush_i,
  input  logic [31:0]                flush_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [CW:0] occ;
  logic        issue;
  logic        push;
  logic        pop;

  always_comb begin
    // The in-flight fetch already owns a slot, so it counts toward occupancy;
    // a same-cycle pop deliberately earns no credit.
    occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue = !rst && !flush_i && (occ < DEPTH_OCC);
    push  = !rst && !flush_i && inflight_q;
    pop   = !rst && !flush_i && (count_q != '0) && id_ready_i;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (flush_i) begin
      fetch_pc_d = {flush_pc_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
        inflight_d    = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
      inst_mem[wr_ptr_q] <= rom_data_i;
    end
  end

  assign rom_ce_o   = issue;
  assign rom_addr_o = fetch_pc_q;
  assign id_valid_o = !rst && (count_q != '0);
  assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr_q] : '0;
  assign count_o    = rst ? '0 : count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_inst_prefetch_q.sv
module tb_inst_prefetch_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i = 32'hDEAD_BEEF;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  inst_prefetch_q #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .id_valid_o (id_valid_o),
    .id_ready_i (id_ready_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  // ROM model: word i holds 0x1000_0000 + i; data appears the cycle after ce.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= 32'h1000_0000 + (rom_addr_o >> 2);
    else          rom_data_i <= 32'hDEAD_BEEF;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", rom_ce_o); end
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (rom_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", rom_addr_o); end
    total++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin bad++; $display("FAIL reset_head got=%h/%h exp=0/0", id_pc_o, id_inst_o); end
    cyc();
  endtask

  task automatic test_stream();
    do_reset();
    id_ready_i = 1'b1;
    #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin bad++; $display("FAIL stream_issue0 got=%b/%h exp=1/0", rom_ce_o, rom_addr_o); end
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL stream_valid_c1 got=%b exp=0", id_valid_o); end
    cyc(); #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h4) begin bad++; $display("FAIL stream_issue1 got=%b/%h exp=1/4", rom_ce_o, rom_addr_o); end
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL stream_valid_c2 got=%b exp=0", id_valid_o); end
    cyc();
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", i, id_valid_o, id_pc_o, 4 * i); end
      total++; if (id_inst_o !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL stream_inst%0d got=%h exp=%h", i, id_inst_o, 32'h1000_0000 + i); end
      total++; if (count_o !== 3'd1) begin bad++; $display("FAIL stream_count%0d got=%0d exp=1", i, count_o); end
      cyc();
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC; exp_pc[4] = 32'h10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'(4 * i)) begin bad++; $display("FAIL fill_issue%0d got=%b/%h exp=1/%h", i, rom_ce_o, rom_addr_o, 4 * i); end
      cyc();
    end
    #1;
    total++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h10) begin bad++; $display("FAIL fill_reserved got=%b/%h exp=0/10", rom_ce_o, rom_addr_o); end
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL fill_count3 got=%0d exp=3", count_o); end
    cyc();
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (count_o !== 3'd4 || rom_ce_o !== 1'b0 || rom_addr_o !== 32'h10) begin bad++; $display("FAIL full_hold%0d got=%0d/%b/%h exp=4/0/10", k, count_o, rom_ce_o, rom_addr_o); end
      cyc();
    end
    id_ready_i = 1'b1;
    #1;
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL drain_no_credit got=%b exp=0", rom_ce_o); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #1;
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc[i]) begin bad++; $display("FAIL drain_pc%0d got=%b/%h exp=1/%h", i, id_valid_o, id_pc_o, exp_pc[i]); end
      total++; if (id_inst_o !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL drain_inst%0d got=%h exp=%h", i, id_inst_o, 32'h1000_0000 + i); end
      if (i == 1) begin
        total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h10) begin bad++; $display("FAIL drain_resume got=%b/%h exp=1/10", rom_ce_o, rom_addr_o); end
      end
      cyc();
    end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(); cyc(); cyc();
    flush_i = 1'b1; flush_pc_i = 32'h100;
    #1;
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", count_o); end
    total++; if (rom_ce_o !== 1'b0) begin bad++; $display("FAIL flush_no_issue got=%b exp=0", rom_ce_o); end
    cyc();
    flush_i = 1'b0;
    #1;
    total++; if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin bad++; $display("FAIL flush_empty got=%b/%0d exp=0/0", id_valid_o, count_o); end
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h100) begin bad++; $display("FAIL flush_target got=%b/%h exp=1/100", rom_ce_o, rom_addr_o); end
    cyc(); #1;
    total++; if (id_valid_o !== 1'b0 || rom_addr_o !== 32'h104) begin bad++; $display("FAIL flush_c2 got=%b/%h exp=0/104", id_valid_o, rom_addr_o); end
    cyc(); #1;
    total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || id_inst_o !== 32'h1000_0040) begin bad++; $display("FAIL flush_head got=%b/%h/%h exp=1/100/10000040", id_valid_o, id_pc_o, id_inst_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL flush_head_count got=%0d exp=1", count_o); end
    cyc();
  endtask

  task automatic test_flush_align_hold();
    flush_i = 1'b1; flush_pc_i = 32'h103;
    cyc();
    flush_i = 1'b0;
    #1;
    total++; if (rom_addr_o !== 32'h100 || rom_ce_o !== 1'b1) begin bad++; $display("FAIL flush_align got=%b/%h exp=1/100", rom_ce_o, rom_addr_o); end
    cyc();
    flush_i = 1'b1; flush_pc_i = 32'h200;
    cyc();
    flush_pc_i = 32'h304;
    #1;
    total++; if (rom_ce_o !== 1'b0 || id_valid_o !== 1'b0 || count_o !== 3'd0) begin bad++; $display("FAIL flush_hold got=%b/%b/%0d exp=0/0/0", rom_ce_o, id_valid_o, count_o); end
    cyc();
    flush_i = 1'b0;
    #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h304) begin bad++; $display("FAIL flush_hold_latest got=%b/%h exp=1/304", rom_ce_o, rom_addr_o); end
    cyc();
  endtask

  task automatic test_wrap();
    id_ready_i = 1'b1;
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    cyc();
    flush_i = 1'b0;
    #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_issue0 got=%b/%h exp=1/fffffffc", rom_ce_o, rom_addr_o); end
    cyc(); #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_issue1 got=%b/%h exp=1/0", rom_ce_o, rom_addr_o); end
    cyc(); #1;
    total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== 32'h4FFF_FFFF) begin bad++; $display("FAIL wrap_head0 got=%b/%h/%h exp=1/fffffffc/4fffffff", id_valid_o, id_pc_o, id_inst_o); end
    cyc(); #1;
    total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== 32'h1000_0000) begin bad++; $display("FAIL wrap_head1 got=%b/%h/%h exp=1/0/10000000", id_valid_o, id_pc_o, id_inst_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(); cyc(); cyc(); cyc();
    #1;
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=3", count_o); end
    rst = 1'b1;
    #1;
    total++; if (rom_ce_o !== 1'b0 || id_valid_o !== 1'b0 || count_o !== 3'd0) begin bad++; $display("FAIL rmid_during got=%b/%b/%0d exp=0/0/0", rom_ce_o, id_valid_o, count_o); end
    total++; if (rom_addr_o !== 32'h10 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin bad++; $display("FAIL rmid_during_bus got=%h/%h/%h exp=10/0/0", rom_addr_o, id_pc_o, id_inst_o); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (count_o !== 3'd0 || id_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0d/%b exp=0/0", count_o, id_valid_o); end
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_restart got=%b/%h exp=1/0", rom_ce_o, rom_addr_o); end
    cyc(); cyc();
    rst = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h200;
    cyc();
    rst = 1'b0; flush_i = 1'b0;
    #1;
    total++; if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'h0) begin bad++; $display("FAIL rst_beats_flush got=%b/%h exp=1/0", rom_ce_o, rom_addr_o); end
    cyc();
  endtask

  initial begin
    cyc();
    test_reset();
    test_stream();
    test_fill_drain();
    test_flush();
    test_flush_align_hold();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
